seq_alu_param: RTL
==================

Name: seq_alu_param

Overview:
- Parametrised multi-cycle integer ALU with a serial operand/result bus; next generation of the 8-bit start/finish ALU.
- Generalised to WIDTH bits.
- Signed Booth radix-2 multiply and restoring divide, with a defined divide-by-zero result.
- Uniform two-beat result protocol for every op.
- Control FSM and datapath are one block; sits between the host bus sequencer and the register file.

Parameters:
WIDTH, 8, operand/bus width in bits (>=4); iteration counter width is clog2(WIDTH)+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
inbus  input  WIDTH  operand bus
op  input  2  00 add, 01 sub, 10 mul, 11 div; sampled with start
start  input  1  begin operation; honoured only in IDLE
outbus  output  WIDTH  result word; 0 when finish low
finish  output  1  high for exactly two cycles (OUT_LO, OUT_HI)
busy  output  1  high in every state except IDLE
div_zero  output  1  high with finish when op=div and divisor=0
state  output  3  debug: current FSM state encoding
A  output  WIDTH  debug: accumulator low WIDTH bits
Q  output  WIDTH  debug: Q register
M  output  WIDTH  debug: M register

Behaviour:
- Reset (rst=1 at edge) from any state, including mid-operation:
  - state=IDLE; all outputs 0; A, Q, M, q-1 and counter cleared.
  - Operation in progress is discarded.
- States:
  - IDLE=0, LOAD_Y=1, EXEC=2, FIXUP=3, OUT_LO=4, OUT_HI=5.
  - Codes 6 and 7 are unreachable; they go to IDLE next cycle.
- IDLE: start=1 at cycle t -> latch op and X=inbus, go to LOAD_Y. start in any other state is ignored.
- LOAD_Y (t+1): latch Y=inbus into M, then go to EXEC.
- EXEC, add/sub:
  - One cycle: A = X+Y or X-Y.
  - Flags word: bit0 = carry-out (add) or borrow, i.e. X<Y unsigned (sub); bit1 = signed overflow; other bits 0.
  - Then OUT_LO.
- EXEC, mul (signed Booth radix-2):
  - A is held as WIDTH+1 bits internally; Q=X, q-1=0.
  - Runs WIDTH cycles. Each cycle: {q0,q-1}=10 -> A-=M; 01 -> A+=M; then arithmetic shift right of {A,Q,q-1}.
  - Product = {A[WIDTH-1:0],Q}, exact for all inputs including -2^(WIDTH-1) squared.
  - Then OUT_LO.
- EXEC, div (restoring):
  - A has WIDTH+1 bits, Q = dividend.
  - Runs WIDTH cycles. Each cycle: shift {A,Q} left, A-=M; if A negative, restore A and q0=0, else q0=1.
  - Then FIXUP.
- FIXUP: one cycle; applies the sign correction described under Optional Feature (no-op in unsigned build).
- Divide by zero:
  - Iterations still run.
  - FIXUP forces quotient to all ones and remainder to the original dividend.
  - div_zero=1 during both OUT beats.
- Output beats:
  - OUT_LO: outbus = sum/difference, product low word, or quotient.
  - OUT_HI: outbus = flags word, product high word, or remainder.
  - OUT_HI -> IDLE; start is accepted again from the following cycle.
- Latency from start cycle t (first finish cycle):
  - add/sub: t+3.
  - mul: t+2+WIDTH.
  - div: t+3+WIDTH.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_DIV_EN.
- Defined: div treats X and Y as two's complement.
  - Magnitudes are divided.
  - FIXUP negates the quotient when the operand signs differ and negates the remainder when the dividend is negative (truncation toward zero).
  - -2^(WIDTH-1)/-1 yields quotient -2^(WIDTH-1), remainder 0.
- Undefined: unsigned division; FIXUP only applies the divide-by-zero override.
- Latency is identical in both builds.

Test Plan:
1. WIDTH=8, add 100,100 -> finish at t+3; outbus 0xC8 then 0x02; div_zero=0.
2. sub 5,7 -> outbus 0xFE then 0x01.
3. mul 0x80,0x80 -> finish first at t+10; outbus 0x00 then 0x40. mul 7,0xFD -> 0xEB then 0xFF.
4. div 200,7:
   - Unsigned build: 0x1C then 0x04, finish first at t+11.
   - SEQ_ALU_SIGNED_DIV_EN build: 0xF8 then 0x00.
5. div 0x55,0 -> outbus 0xFF then 0x55; div_zero=1 for both beats.
6. start mul 3,5, pulse start again at t+4, then rst=1 at t+5:
   - Second start ignored.
   - Next cycle state=0, busy=0, outbus=0; no finish.
   - A new add issued afterwards completes normally.

Source files
------------

// File: rtl/seq_alu_param_if.sv
// Host-side bus bundle for seq_alu_param: the operand and op inputs, start/finish
// handshake, serial result word and status flags.
interface seq_alu_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] inbus;
    logic [1:0]       op;
    logic             start;
    logic [WIDTH-1:0] outbus;
    logic             finish;
    logic             busy;
    logic             div_zero;

    modport master (
        output inbus, op, start,
        input  outbus, finish, busy, div_zero
    );

    modport slave (
        input  inbus, op, start,
        output outbus, finish, busy, div_zero
    );
endinterface

// File: rtl/seq_alu_param.sv
// Multi-cycle WIDTH-bit ALU: add/sub, Booth multiply and restoring divide with a
// two-beat result. Define SEQ_ALU_SIGNED_DIV_EN for two's complement division.
module seq_alu_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_alu_param_if.slave   bus,
    output logic [2:0]       state,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] M
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        EXEC   = 3'd2,
        FIXUP  = 3'd3,
        OUT_LO = 3'd4,
        OUT_HI = 3'd5
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] dvd;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    logic             y_neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    logic [WIDTH:0]   sum_ext;
    logic             ovf;
    logic [WIDTH-1:0] flags;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_neg;
    logic             is_arith;
    logic             last_iter;

    assign is_arith  = ~op_reg[1];
    assign last_iter = (cnt == CNT_W'(1));

    always_comb begin
        sum_ext = op_reg[0] ? ({1'b0, q_reg} - {1'b0, m_reg})
                            : ({1'b0, q_reg} + {1'b0, m_reg});
        ovf     = (op_reg[0] ? (q_reg[WIDTH-1] ^ m_reg[WIDTH-1])
                             : ~(q_reg[WIDTH-1] ^ m_reg[WIDTH-1]))
                  & (sum_ext[WIDTH-1] ^ q_reg[WIDTH-1]);
        flags   = {{(WIDTH-2){1'b0}}, ovf, sum_ext[WIDTH]};

        m_ext = {m_reg[WIDTH-1], m_reg};
        case ({q_reg[0], q_m1})
            2'b10:   booth = acc - m_ext;
            2'b01:   booth = acc + m_ext;
            default: booth = acc;
        endcase

        // Top bit of the trial difference is set exactly when the shifted remainder < M.
        div_shift = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_reg};
        div_neg   = div_diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) cur_state <= IDLE;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:   if (bus.start) nxt_state = LOAD_Y;
            LOAD_Y: nxt_state = EXEC;
            EXEC: begin
                if (is_arith)               nxt_state = OUT_LO;
                else if (last_iter)         nxt_state = (op_reg == OP_DIV) ? FIXUP : OUT_LO;
            end
            FIXUP:  nxt_state = OUT_LO;
            OUT_LO: nxt_state = OUT_HI;
            OUT_HI: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            q_reg  <= '0;
            m_reg  <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            op_reg <= '0;
            dvd    <= '0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
            y_neg  <= 1'b0;
`endif
        end else begin
            case (cur_state)
                IDLE: if (bus.start) begin
                    op_reg <= bus.op;
                    q_reg  <= bus.inbus;
                    dvd    <= bus.inbus;
                    acc    <= '0;
                    q_m1   <= 1'b0;
                end
                LOAD_Y: begin
                    cnt <= CNT_W'(WIDTH);
`ifdef SEQ_ALU_SIGNED_DIV_EN
                    y_neg <= bus.inbus[WIDTH-1];
                    if (op_reg == OP_DIV) begin
                        m_reg <= mag(bus.inbus);
                        q_reg <= mag(q_reg);
                    end else begin
                        m_reg <= bus.inbus;
                    end
`else
                    m_reg <= bus.inbus;
`endif
                end
                EXEC: begin
                    if (is_arith) begin
                        acc   <= {1'b0, sum_ext[WIDTH-1:0]};
                        q_reg <= flags;
                    end else if (op_reg == OP_MUL) begin
                        acc   <= {booth[WIDTH], booth[WIDTH:1]};
                        q_reg <= {booth[0], q_reg[WIDTH-1:1]};
                        q_m1  <= q_reg[0];
                        cnt   <= cnt - CNT_W'(1);
                    end else begin
                        acc   <= div_neg ? div_shift : div_diff;
                        q_reg <= {q_reg[WIDTH-2:0], ~div_neg};
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                FIXUP: begin
                    if (m_reg == '0) begin
                        q_reg <= '1;
                        acc   <= {1'b0, dvd};
                    end else begin
`ifdef SEQ_ALU_SIGNED_DIV_EN
                        if (dvd[WIDTH-1] ^ y_neg) q_reg <= -q_reg;
                        if (dvd[WIDTH-1])         acc   <= {1'b0, -acc[WIDTH-1:0]};
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy     = (cur_state != IDLE);
        bus.finish   = (cur_state == OUT_LO) || (cur_state == OUT_HI);
        bus.div_zero = bus.finish && (op_reg == OP_DIV) && (m_reg == '0);
        bus.outbus   = '0;
        if (cur_state == OUT_LO)      bus.outbus = is_arith ? acc[WIDTH-1:0] : q_reg;
        else if (cur_state == OUT_HI) bus.outbus = is_arith ? q_reg : acc[WIDTH-1:0];
    end

    assign state = cur_state;
    assign A     = acc[WIDTH-1:0];
    assign Q     = q_reg;
    assign M     = m_reg;
endmodule
